mem_arbiter: RTL and testbench

Two-port arbiter that shares the single word-addressed Memory between the CPU and the IOP (I/O processor / DMA channel). It accepts one access at a time from either requester, latches it, drives the Memory address, byte-lane write-enable and data buses, and returns read data with a one-cycle acknowledge. It sits between the CPU/IOP and the Memory in the top-level test bench and system.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared definitions for the CPU/IOP memory arbiter: FSM state
//            encoding, requester IDs and bus widths.
// Contents : state_t (ST_IDLE, ST_ACCESS, ST_DONE), REQ_CPU, REQ_IOP,
//            ADDR_W, DATA_W, ADDR_LO (lowest bit index of the [ADDR_LO:31]
//            word-address bus).
// Revision : 1.0 - initial release
// =============================================================================
package mem_arb_pkg;

   localparam int ADDR_W  = 17;
   localparam int DATA_W  = 32;
   localparam int ADDR_LO = 32 - ADDR_W;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_IOP = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// =============================================================================
// Module   : rr_pick
// Purpose  : Two-input round-robin picker. Requests are first filtered by a
//            lock mask; on a tie the requester that was not served last wins.
// Ports    : i_reqs      [1:0] request vector, bit REQ_CPU / bit REQ_IOP
//            i_last            ID of the requester served last
//            i_lock_mask [1:0] per-requester grant permission
//            o_grant           granted requester ID
//            o_valid           at least one permitted request present
// Revision : 1.0 - initial release
// =============================================================================
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] i_reqs,
   input  logic       i_last,
   input  logic [1:0] i_lock_mask,
   output logic       o_grant,
   output logic       o_valid
);

   logic [1:0] w_req;

   assign w_req   = i_reqs & i_lock_mask;
   assign o_valid = |w_req;

   always_comb begin
      o_grant = REQ_CPU;
      if (&w_req) begin
         o_grant = ~i_last;
      end else if (w_req[REQ_IOP]) begin
         o_grant = REQ_IOP;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one word-addressed Memory between the CPU and the IOP.
//            One access at a time is latched, driven onto the Memory bus for
//            1+WAIT_STATES cycles, and completed with a one-cycle ack.
// Params   : WAIT_STATES  extra Memory-bus cycles per access (0..15)
// Macro    : MEM_ARB_LOCK_EN adds c_lock/i_lock for locked (atomic) sequences
// Ports    : clock, reset (async, active high)
//            c_req/c_address/c_write_en/c_data_in -> c_ack/c_data_out  (CPU)
//            i_req/i_address/i_write_en/i_data_in -> i_ack/i_data_out  (IOP)
//            m_address/m_write_en/m_data_out -> Memory, m_data_in <- Memory
//            busy (ACCESS or DONE), owner (0 = CPU, 1 = IOP)
// Revision : 1.0 - initial release
// =============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0
)(
   input  logic              clock,
   input  logic              reset,
`ifdef MEM_ARB_LOCK_EN
   input  logic              c_lock,
   input  logic              i_lock,
`endif
   input  logic              c_req,
   input  logic [ADDR_LO:31] c_address,
   input  logic [0:3]        c_write_en,
   input  logic [0:DATA_W-1] c_data_in,
   output logic              c_ack,
   output logic [0:DATA_W-1] c_data_out,
   input  logic              i_req,
   input  logic [ADDR_LO:31] i_address,
   input  logic [0:3]        i_write_en,
   input  logic [0:DATA_W-1] i_data_in,
   output logic              i_ack,
   output logic [0:DATA_W-1] i_data_out,
   output logic [ADDR_LO:31] m_address,
   output logic [0:3]        m_write_en,
   output logic [0:DATA_W-1] m_data_out,
   input  logic [0:DATA_W-1] m_data_in,
   output logic              busy,
   output logic              owner
);

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic              r_last;
   logic              r_owner;
   logic [ADDR_LO:31] r_addr;
   logic [0:3]        r_we;
   logic [0:DATA_W-1] r_wdata;
   logic [0:DATA_W-1] r_c_rdata;
   logic [0:DATA_W-1] r_i_rdata;
   logic              w_grant;
   logic              w_valid;
   logic              w_grant_en;
   logic              w_mem_cycle;
   logic [1:0]        w_lock_mask;

   rr_pick u_pick (
      .i_reqs      ({i_req, c_req}),
      .i_last      (r_last),
      .i_lock_mask (w_lock_mask),
      .o_grant     (w_grant),
      .o_valid     (w_valid)
   );

`ifdef MEM_ARB_LOCK_EN
   logic r_lock_held;
   logic r_lock_id;
   logic r_cur_lock;

   // The lock flag of the running access decides, at its completion, whether
   // the bus stays reserved for the same requester.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_lock_held <= 1'b0;
         r_lock_id   <= REQ_CPU;
         r_cur_lock  <= 1'b0;
      end else begin
         if (w_grant_en) begin
            r_cur_lock <= w_grant ? i_lock : c_lock;
         end
         if (r_state == ST_DONE) begin
            r_lock_held <= r_cur_lock;
            r_lock_id   <= r_owner;
         end
      end
   end

   assign w_lock_mask = r_lock_held ? (r_lock_id ? 2'b10 : 2'b01) : 2'b11;
`else
   assign w_lock_mask = 2'b11;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Write enables are decoded from state and counter so that an asynchronous
   // reset kills a pending write pulse immediately.
   always_comb begin
      w_next      = r_state;
      w_grant_en  = 1'b0;
      w_mem_cycle = 1'b0;
      c_ack       = 1'b0;
      i_ack       = 1'b0;
      m_write_en  = 4'b0000;
      unique case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_grant_en = 1'b1;
               w_next     = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (r_cnt == 4'd0) begin
               w_mem_cycle = 1'b1;
               m_write_en  = r_we;
               w_next      = ST_DONE;
            end
         end
         ST_DONE: begin
            c_ack  = (r_owner == REQ_CPU);
            i_ack  = (r_owner == REQ_IOP);
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt     <= 4'd0;
         r_last    <= REQ_IOP;
         r_owner   <= REQ_CPU;
         r_addr    <= '0;
         r_we      <= 4'b0000;
         r_wdata   <= '0;
         r_c_rdata <= '0;
         r_i_rdata <= '0;
      end else begin
         if (w_grant_en) begin
            r_owner <= w_grant;
            r_addr  <= w_grant ? i_address  : c_address;
            r_we    <= w_grant ? i_write_en : c_write_en;
            r_wdata <= w_grant ? i_data_in  : c_data_in;
            r_cnt   <= 4'(WAIT_STATES);
         end else if (r_state == ST_ACCESS && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_mem_cycle) begin
            if (r_owner == REQ_IOP) begin
               r_i_rdata <= m_data_in;
            end else begin
               r_c_rdata <= m_data_in;
            end
         end
         if (r_state == ST_DONE) begin
            r_last <= r_owner;
         end
      end
   end

   assign m_address  = r_addr;
   assign m_data_out = r_wdata;
   assign c_data_out = r_c_rdata;
   assign i_data_out = r_i_rdata;
   assign busy       = (r_state != ST_IDLE);
   assign owner      = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter (WAIT_STATES = 3). Provides
//            the Memory, a table of directed accesses, hand sequences for
//            reset-abort and (with MEM_ARB_LOCK_EN) locking, and random
//            traffic checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mem_arbiter;

   localparam int WS = 3;
   localparam int TO = 4 * (3 + WS) + 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
`ifdef MEM_ARB_LOCK_EN
   logic        c_lock = 1'b0;
   logic        i_lock = 1'b0;
`endif
   logic        c_req = 1'b0;
   logic [15:31] c_address = '0;
   logic [0:3]  c_write_en = '0;
   logic [0:31] c_data_in = '0;
   logic        c_ack;
   logic [0:31] c_data_out;
   logic        i_req = 1'b0;
   logic [15:31] i_address = '0;
   logic [0:3]  i_write_en = '0;
   logic [0:31] i_data_in = '0;
   logic        i_ack;
   logic [0:31] i_data_out;
   logic [15:31] m_address;
   logic [0:3]  m_write_en;
   logic [0:31] m_data_out;
   logic [0:31] m_data_in;
   logic        busy;
   logic        owner;

   mem_arbiter #(.WAIT_STATES(WS)) u_dut (
      .clock      (clock),
      .reset      (reset),
`ifdef MEM_ARB_LOCK_EN
      .c_lock     (c_lock),
      .i_lock     (i_lock),
`endif
      .c_req      (c_req),
      .c_address  (c_address),
      .c_write_en (c_write_en),
      .c_data_in  (c_data_in),
      .c_ack      (c_ack),
      .c_data_out (c_data_out),
      .i_req      (i_req),
      .i_address  (i_address),
      .i_write_en (i_write_en),
      .i_data_in  (i_data_in),
      .i_ack      (i_ack),
      .i_data_out (i_data_out),
      .m_address  (m_address),
      .m_write_en (m_write_en),
      .m_data_out (m_data_out),
      .m_data_in  (m_data_in),
      .busy       (busy),
      .owner      (owner)
   );

   always #5 clock = ~clock;

   // Lane 0 is the leftmost enable bit and the most significant byte.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] we);
      merge = old;
      for (int l = 0; l < 4; l++) begin
         if (we[3-l]) merge[31-8*l -: 8] = nw[31-8*l -: 8];
      end
   endfunction

   function automatic logic [31:0] init_word(input int i);
      if (i == 'h10) return 32'h12345678;
      if (i == 'h20) return 32'h11223344;
      return 32'hA5000000 | 32'(i);
   endfunction

   // Memory: combinational read, byte-lane write on the rising edge.
   logic [31:0] mem [0:131071];
   bit          mem_ready = 1'b0;
   assign m_data_in = mem[m_address];
   always @(posedge clock) begin
      if (!mem_ready) begin
         for (int i = 0; i < 131072; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (m_write_en != 4'b0000) begin
         mem[m_address] <= merge(mem[m_address], m_data_out, m_write_en);
      end
   end

   // Reference model state: expected memory contents and last-served requester.
   logic [31:0] exp_mem [0:131071];
   bit          model_last = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      bit          c_en;
      bit          i_en;
      logic [3:0]  c_we;
      logic [3:0]  i_we;
      logic [16:0] c_a;
      logic [16:0] i_a;
      logic [31:0] c_d;
      logic [31:0] i_d;
      bit          exp_first;
      logic [31:0] exp_c_rd;
      logic [31:0] exp_i_rd;
   } vec_t;

   // Transaction-level model: decide the service order from the round-robin
   // rule, then perform the accesses on exp_mem in that order.
   task automatic model_pair(inout vec_t v);
      bit          who;
      logic [16:0] a;
      logic [3:0]  we;
      logic [31:0] d;
      v.exp_first = (v.c_en && v.i_en) ? !model_last : v.i_en;
      v.exp_c_rd  = '0;
      v.exp_i_rd  = '0;
      for (int s = 0; s < 2; s++) begin
         who = (s == 0) ? v.exp_first : !v.exp_first;
         if (who ? v.i_en : v.c_en) begin
            a  = who ? v.i_a  : v.c_a;
            we = who ? v.i_we : v.c_we;
            d  = who ? v.i_d  : v.c_d;
            if (who) v.exp_i_rd = exp_mem[a];
            else     v.exp_c_rd = exp_mem[a];
            if (we != 4'b0000) exp_mem[a] = merge(exp_mem[a], d, we);
            model_last = who;
         end
      end
   endtask

   // Present one or two simultaneous requests and check every completion.
   task automatic apply(input vec_t v);
      int          n, nacc, pulse_n, pulses, ack1_n, nwr;
      bit          got_c, got_i, both, who, exp_who;
      logic [3:0]  pulse_val, we;
      logic [31:0] rd, exp_rd;
      both = v.c_en && v.i_en;
      nwr  = ((v.c_en && v.c_we != 4'b0) ? 1 : 0) + ((v.i_en && v.i_we != 4'b0) ? 1 : 0);
      @(negedge clock);
      c_req = v.c_en; c_address = v.c_a; c_write_en = v.c_we; c_data_in = v.c_d;
      i_req = v.i_en; i_address = v.i_a; i_write_en = v.i_we; i_data_in = v.i_d;
      n = 0; nacc = 0; pulses = 0; pulse_n = -100; ack1_n = -100; pulse_val = '0;
      got_c = !v.c_en; got_i = !v.i_en;
      while (!(got_c && got_i) && n < TO) begin
         @(negedge clock);
         n++;
         if (m_write_en != 4'b0000) begin
            pulses++;
            pulse_n   = n;
            pulse_val = m_write_en;
         end
         if (both && n == ack1_n + 1) chk("gap_busy_low", busy, 0);
         if (both && n == ack1_n + 2) chk("regrant_busy", busy, 1);
         if (c_ack || i_ack) begin
            who = i_ack;
            nacc++;
            exp_who = (nacc == 1) ? v.exp_first : !v.exp_first;
            chk("single_ack", c_ack & i_ack, 0);
            chk("ack_owner", who, exp_who);
            chk("owner_out", owner, exp_who);
            chk("ack_latency", n, (nacc == 1) ? 2 + WS : 5 + 2 * WS);
            we = exp_who ? v.i_we : v.c_we;
            if (we == 4'b0000) begin
               rd     = exp_who ? i_data_out : c_data_out;
               exp_rd = exp_who ? v.exp_i_rd : v.exp_c_rd;
               chk("read_data", rd, exp_rd);
            end else begin
               chk("we_pulse_cycle", pulse_n, n - 1);
               chk("we_pulse_lanes", pulse_val, we);
            end
            if (who) begin i_req = 1'b0; got_i = 1'b1; end
            else     begin c_req = 1'b0; got_c = 1'b1; end
            if (nacc == 1) ack1_n = n;
         end
      end
      chk("acks_seen", nacc, (v.c_en ? 1 : 0) + (v.i_en ? 1 : 0));
      chk("we_pulse_count", pulses, nwr);
   endtask

   // Bounded wait for either ack; returns which ones fired (both 0 on timeout).
   task automatic wait_ack(output bit ca, output bit ia);
      int n;
      n = 0; ca = 1'b0; ia = 1'b0;
      while (!(ca || ia) && n < TO) begin
         @(negedge clock);
         n++;
         ca = c_ack; ia = i_ack;
      end
   endtask

   vec_t tbl [10];
   vec_t v;
   vec_t tmp;
   int   sel;
   int   acks;
   bit   ca, ia;

   initial begin
      for (int i = 0; i < 131072; i++) exp_mem[i] = init_word(i);
      //           c_en  i_en  c_we     i_we     c_a        i_a        c_d            i_d            first  exp_c_rd       exp_i_rd
      tbl[0] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 17'h00010, 17'h00000, 32'h0,         32'h0,         1'b0, 32'h12345678, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 4'b0000, 4'b0101, 17'h00000, 17'h00020, 32'h0,         32'hAABBCCDD, 1'b1, 32'h0,         32'h0};
      tbl[2] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 17'h00000, 17'h00020, 32'h0,         32'h0,         1'b1, 32'h0,         32'h11BB33DD};
      tbl[3] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 17'h00010, 17'h00020, 32'h0,         32'h0,         1'b0, 32'h12345678, 32'h11BB33DD};
      tbl[4] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 17'h00030, 17'h00011, 32'hDEADBEEF, 32'h0,         1'b0, 32'h0,         32'hA5000011};
      tbl[5] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 17'h00030, 17'h00000, 32'h0,         32'h0,         1'b0, 32'hDEADBEEF, 32'h0};
      tbl[6] = '{1'b1, 1'b1, 4'b1000, 4'b0011, 17'h00010, 17'h00030, 32'h99000000, 32'h0000CAFE, 1'b1, 32'h0,         32'h0};
      tbl[7] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 17'h00030, 17'h00010, 32'h0,         32'h0,         1'b1, 32'hDEADCAFE, 32'h99345678};
      tbl[8] = '{1'b0, 1'b1, 4'b0000, 4'b1111, 17'h00000, 17'h18005, 32'h0,         32'h01020304, 1'b1, 32'h0,         32'h0};
      tbl[9] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 17'h18005, 17'h08005, 32'h0,         32'h0,         1'b0, 32'h01020304, 32'hA5008005};

      // Reset values while reset is held.
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_c_ack", c_ack, 0);
      chk("rst_i_ack", i_ack, 0);
      chk("rst_m_address", m_address, 0);
      chk("rst_m_write_en", m_write_en, 0);
      chk("rst_m_data_out", m_data_out, 0);
      chk("rst_c_data_out", c_data_out, 0);
      chk("rst_i_data_out", i_data_out, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      for (int k = 0; k < 10; k++) begin
         tmp = tbl[k];
         model_pair(tmp);
         apply(tbl[k]);
      end
      chk("mem_0x20_lanes", mem[17'h20], 32'h11BB33DD);

      // Reset during ACCESS before the write cycle: no write, no ack.
      @(negedge clock);
      i_req = 1'b1; i_address = 17'h40; i_write_en = 4'b1111; i_data_in = 32'hFFFFFFFF;
      @(negedge clock);
      chk("pre_reset_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_owner", owner, 0);
      chk("abort_i_ack", i_ack, 0);
      chk("abort_m_write_en", m_write_en, 0);
      chk("abort_m_address", m_address, 0);
      chk("abort_m_data_out", m_data_out, 0);
      chk("abort_i_data_out", i_data_out, 0);
      chk("abort_c_data_out", c_data_out, 0);
      @(negedge clock);
      i_req = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      model_last = 1'b1;
      acks = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         acks += (c_ack ? 1 : 0) + (i_ack ? 1 : 0);
      end
      chk("abort_no_ack", acks, 0);
      chk("abort_mem_kept", mem[17'h40], exp_mem[17'h40]);

`ifdef MEM_ARB_LOCK_EN
      // Locked CPU read then unlocked CPU write while the IOP waits.
      @(negedge clock);
      c_req = 1'b1; c_lock = 1'b1; c_address = 17'h10; c_write_en = 4'b0000;
      i_req = 1'b1; i_lock = 1'b0; i_address = 17'h20; i_write_en = 4'b0000;
      wait_ack(ca, ia);
      chk("lock_first_cpu", {30'b0, ia, ca}, 32'b01);
      chk("lock_rd", c_data_out, exp_mem[17'h10]);
      c_req = 1'b0; c_lock = 1'b0;
      acks = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         acks += busy ? 1 : 0;
      end
      chk("lock_iop_blocked", acks, 0);
      c_req = 1'b1; c_address = 17'h50; c_write_en = 4'b1111; c_data_in = 32'h5A5A5A5A;
      wait_ack(ca, ia);
      chk("lock_second_cpu", {30'b0, ia, ca}, 32'b01);
      c_req = 1'b0; c_write_en = 4'b0000;
      exp_mem[17'h50] = 32'h5A5A5A5A;
      wait_ack(ca, ia);
      chk("lock_then_iop", {30'b0, ia, ca}, 32'b10);
      chk("lock_iop_rd", i_data_out, exp_mem[17'h20]);
      i_req = 1'b0;
      chk("lock_mem_wr", mem[17'h50], 32'h5A5A5A5A);
      model_last = 1'b1;
`endif

      // Random traffic against the reference model.
      for (int k = 0; k < 40; k++) begin
         sel    = $urandom_range(1, 3);
         v.c_en = sel[0];
         v.i_en = sel[1];
         v.c_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
         v.i_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
         v.c_a  = 17'($urandom) & 17'h1803F;
         v.i_a  = 17'($urandom) & 17'h1803F;
         v.c_d  = $urandom;
         v.i_d  = $urandom;
         model_pair(v);
         apply(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
